// File: rtl/mchan_trans_queue_mc.sv
// Shared-buffer transaction queue feeding NB_CH independent FIFO channels.
// Descriptors are steered by a select field; each channel has an occupancy cap.
module mchan_trans_queue_mc #(
  parameter int NB_CH     = 2,
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 64,
  parameter int SEL_LSB   = 48,
  parameter int LOG_CH    = (NB_CH == 1) ? 1 : $clog2(NB_CH),
  parameter int CH_MAX    = DEPTH,
  parameter int LOG_DEPTH = (DEPTH == 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [WIDTH-1:0]       dat_i,
  output logic [NB_CH-1:0]       ch_req_o,
  input  logic [NB_CH-1:0]       ch_gnt_i,
  output logic [NB_CH*WIDTH-1:0] ch_dat_o,
  output logic                   err_o,
  output logic [LOG_DEPTH:0]     elements_o
);

  localparam int CW = LOG_DEPTH + 1;

  typedef logic [LOG_DEPTH-1:0] ptr_t;
  typedef logic [CW-1:0]        cnt_t;

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] buf_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  ptr_t             ord_q [NB_CH][DEPTH];
  ptr_t             ord_d [NB_CH][DEPTH];
  ptr_t             hd_q  [NB_CH];
  ptr_t             hd_d  [NB_CH];
  ptr_t             tl_q  [NB_CH];
  ptr_t             tl_d  [NB_CH];
  cnt_t             cnt_q [NB_CH];
  cnt_t             cnt_d [NB_CH];
  cnt_t             tot_q, tot_d;
  logic             err_q, err_d;

  logic [LOG_CH-1:0] sel;
  logic              sel_oor;
  cnt_t              cnt_sel;
  logic              push;
  logic [NB_CH-1:0]  pop;
  ptr_t              free_slot;
  logic              free_found;

  function automatic ptr_t nxt(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign sel     = dat_i[SEL_LSB +: LOG_CH];
  assign sel_oor = (32'(sel) >= 32'(NB_CH));

  always_comb begin
    cnt_sel = '0;
    if (!sel_oor) cnt_sel = cnt_q[sel];
  end

  assign gnt_o = !clear_i &&
                 (sel_oor ||
                  (tot_q < cnt_t'(DEPTH) &&
                   cnt_sel < cnt_t'(CH_MAX)));

  assign push = req_i && gnt_o && !sel_oor;

  // Lowest free slot, taken from the registered busy map only
  always_comb begin
    free_slot  = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_slot  = ptr_t'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      pop[c] = ch_gnt_i[c] && (cnt_q[c] != '0);
    end
  end

  always_comb begin
    buf_d  = buf_q;
    busy_d = busy_q;
    ord_d  = ord_q;
    hd_d   = hd_q;
    tl_d   = tl_q;
    cnt_d  = cnt_q;
    tot_d  = tot_q;
    err_d  = req_i && gnt_o && sel_oor;
    if (clear_i) begin
      busy_d = '0;
      tot_d  = '0;
      err_d  = 1'b0;
      for (int c = 0; c < NB_CH; c++) begin
        hd_d[c]  = '0;
        tl_d[c]  = '0;
        cnt_d[c] = '0;
      end
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        if (pop[c]) begin
          busy_d[ord_q[c][hd_q[c]]] = 1'b0;
          hd_d[c]  = nxt(hd_q[c]);
          cnt_d[c] = cnt_q[c] - cnt_t'(1);
          tot_d    = tot_d - cnt_t'(1);
        end
      end
      // Push slot is free in busy_q, so it never collides with a popped slot
      if (push) begin
        buf_d[free_slot]       = dat_i;
        busy_d[free_slot]      = 1'b1;
        ord_d[sel][tl_q[sel]]  = free_slot;
        tl_d[sel]              = nxt(tl_q[sel]);
        cnt_d[sel]             = cnt_d[sel] + cnt_t'(1);
        tot_d                  = tot_d + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q  <= '{default: '0};
      busy_q <= '0;
      ord_q  <= '{default: '{default: '0}};
      hd_q   <= '{default: '0};
      tl_q   <= '{default: '0};
      cnt_q  <= '{default: '0};
      tot_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      busy_q <= busy_d;
      ord_q  <= ord_d;
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      cnt_q  <= cnt_d;
      tot_q  <= tot_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      ch_req_o[c]                = (cnt_q[c] != '0);
      ch_dat_o[c*WIDTH +: WIDTH] = buf_q[ord_q[c][hd_q[c]]];
    end
  end

  assign err_o      = err_q;
  assign elements_o = tot_q;

endmodule

// File: doc/mchan_trans_queue_mc.md
# mchan_trans_queue_mc

Multi-channel transaction queue for the mchan control unit. It accepts DMA transaction descriptors on a single push port and stores them in one shared buffer. Each descriptor is steered to one of NB_CH output channels (for example TX, RX, or extra TCDM/ext engines) by a select field inside the descriptor. Each channel keeps strict FIFO order independently, and a per-channel occupancy cap stops one channel from starving the others of buffer slots.

## Interface
Parameters:
- NB_CH, 2, number of output channels (≥1)
- DEPTH, 4, shared buffer slots (≥2)
- WIDTH, 64, descriptor width
- SEL_LSB, 48, bit position of the channel-select field in dat_i
- LOG_CH, (NB_CH==1)?1:$clog2(NB_CH), select field width; field is dat_i[SEL_LSB+LOG_CH-1:SEL_LSB]
- CH_MAX, DEPTH, max slots one channel may occupy (1..DEPTH)
- LOG_DEPTH, (DEPTH==1)?1:$clog2(DEPTH), derived

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  synchronous flush of all contents
- req_i  in  1  push request
- gnt_o  out  1  push accepted this cycle
- dat_i  in  WIDTH  descriptor
- ch_req_o  out  NB_CH  channel c has a descriptor at its head
- ch_gnt_i  in  NB_CH  channel c consumes its head
- ch_dat_o  out  NB_CH×WIDTH  head descriptor for each channel
- err_o  out  1  one-cycle pulse when a push has an out-of-range select field
- elements_o  out  LOG_DEPTH+1  total occupied slots (registered)

## Operation
- State:
  - buffer[DEPTH]
  - busy[DEPTH]
  - per channel: order table ord[c][DEPTH] of slot indices, head/tail pointers (LOG_DEPTH bits, wrap DEPTH-1→0), count[c] (LOG_DEPTH+1 bits)
  - total count
- sel = select field of dat_i.
- gnt_o = !clear_i && (sel≥NB_CH || (total<DEPTH && count[sel]<CH_MAX)). It is combinational from registered state and dat_i.
- Push = req_i && gnt_o:
  - sel<NB_CH: free slot = lowest-index slot with busy==0 (from registered busy).
    - buffer[slot]←dat_i; busy[slot]←1
    - ord[sel][tail[sel]]←slot; tail[sel] advances; count[sel] and total increment
  - sel≥NB_CH: descriptor dropped, err_o=1 next cycle for one cycle, no state change.
- Pop on channel c = ch_req_o[c] && ch_gnt_i[c]:
  - busy[ord[c][head[c]]]←0; head[c] advances; count[c] and total decrement
- Any combination of one push and up to NB_CH pops in a cycle is legal.
  - Total update = +push − popcount(pops).
  - Per-channel update = +(push to c) − (pop c).
- ch_dat_o[c] = buffer[ord[c][head[c]]]. Ignore it when ch_req_o[c]=0.
- ch_req_o[c] = (count[c]!=0).
- clear_i: next edge zeroes busy, counts, pointers and total. Buffer contents are kept. Pushes and pops in that cycle are ignored. rst_i additionally zeroes buffer and ord.
- Bit 0 of a 1-bit select field is used as-is when NB_CH==1. Values ≥1 are errors.

## Timing
- Reset values (edge with rst_i=1):
  - ch_req_o=0, err_o=0, elements_o=0
  - ch_dat_o=0 (all buffer entries cleared)
  - gnt_o=1 for in-range sel
- Push latency: accepted at edge k → ch_req_o[sel]=1 and ch_dat_o valid after edge k (1 cycle). No same-cycle bypass.
- A slot freed by a pop at edge k can be reused by a push from edge k+1 onward.
- Full boundary: when total==DEPTH, gnt_o=0 even if pops occur in the same cycle. gnt_o returns in the cycle after the pop edge.
- Cap boundary: when count[sel]==CH_MAX, gnt_o=0 for that sel only. Pushes to other channels still proceed.
- Empty channel: ch_gnt_i[c] with ch_req_o[c]=0 has no effect.
- Pointer wrap: head/tail go DEPTH-1→0. Counters never under- or overflow under legal handshakes.
- ch_dat_o[c] stays stable while ch_req_o[c]=1 and no pop occurs on c. Pushes to c only write the tail.
- Reset or clear mid-burst: outstanding descriptors are lost. The next cycle behaves as after reset, except ch_dat_o after clear.

## Test plan
- Reset, then push ch0 A, ch1 B, ch0 C on consecutive cycles. ch_req_o=2'b11 one cycle after B. ch_dat_o[0]=A. Pop ch0 → ch_dat_o[0]=C, elements_o=2.
- DEPTH=4, CH_MAX=4, push 4 to ch1. gnt_o=0 on the 5th. Pop ch1 and push in the same cycle → push refused. Push the next cycle → accepted, lands in slot 0, elements_o=4.
- CH_MAX=2, DEPTH=4, push 3 to ch0. The 3rd is refused. A push to ch1 in the next cycle is accepted.
- Interleave ch0/ch1 pushes and pops to cycle the slots (busy pattern 1010 → free slot 1). Run ≥3 full wraps of every head/tail. Each channel's output order equals its push order.
- Push with sel=3 and NB_CH=3. gnt_o=1, err_o pulses the next cycle, ch_req_o and elements_o unchanged.
- Fill 3 entries, assert clear_i with a concurrent push and pop. Next cycle ch_req_o=0, elements_o=0. A subsequent push lands in slot 0.
